// File: rtl/uart_rx_fifo_if.sv
// Bus-side signal bundle of the UART receive path: serial line in, FIFO read port
// and sticky error status out.
interface uart_rx_fifo_if #(
    parameter int CNT_W = 5
);
    logic             uart_rxd;
    logic             rd_en;
    logic             err_clr;
    logic [7:0]       rd_data;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             frame_err;
    logic             parity_err;
    logic             overrun;

    modport slave (
        input  uart_rxd, rd_en, err_clr,
        output rd_data, empty, full, count, frame_err, parity_err, overrun
    );

    modport master (
        output uart_rxd, rd_en, err_clr,
        input  rd_data, empty, full, count, frame_err, parity_err, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable data bits, parity and baud divisor) feeding a
// first-word-fall-through receive FIFO with sticky frame/parity/overrun flags.
module uart_rx_fifo #(
    parameter int CLK_DIV     = 434,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int FIFO_DEPTH  = 16,
    parameter int CNT_W       = 5
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BC_W  = $clog2(CLK_DIV);
    localparam int SHIFT = 8 - DATA_BITS;
    localparam logic [BC_W-1:0] BC_HALF = BC_W'(CLK_DIV / 2 - 1);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0] BC_ZERO = BC_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Data bits are zero-extended, so the XOR over all 8 bits equals the XOR of the data field.
    function automatic logic parity_bad(input logic [7:0] data, input logic par);
        logic x;
        x = (^data) ^ par;
        case (PARITY_MODE)
            1:       parity_bad = (x != 1'b1);
            2:       parity_bad = (x != 1'b0);
            default: parity_bad = 1'b0;
        endcase
    endfunction

    logic                   sync1_r, sync2_r;
    logic                   rxd_s;
    state_t                 state_r;
    logic [BC_W-1:0]        bc_r;
    logic [7:0]             shift_r;
    logic [3:0]             bit_cnt_r;
    logic                   par_bad_r;
    logic [7:0]             data_s;

    logic [7:0]             mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]       count_r, count_n_s;
    logic                   empty_r, full_r;
    logic                   frame_err_r, parity_err_r, overrun_r;

    logic                   stop_cyc_s, pop_s, push_s;
    logic                   frame_set_s, parity_set_s, overrun_set_s;

    assign rxd_s = sync2_r;

    // Two-flop synchroniser for the asynchronous serial line, idling high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= bus.uart_rxd;
            sync2_r <= sync1_r;
        end
    end

    // Bits arrive LSB first into the top of the shifter; right-align the data field.
    always_comb begin
        data_s = shift_r >> SHIFT;
    end

    // Receive FSM with baud counter: sample mid-bit, parity and stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            bc_r      <= BC_ZERO;
            shift_r   <= 8'h00;
            bit_cnt_r <= 4'd0;
            par_bad_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        bc_r    <= BC_HALF;
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (bc_r == BC_ZERO) begin
                        if (rxd_s) begin
                            state_r <= ST_IDLE;
                        end else begin
                            bc_r      <= BC_FULL;
                            bit_cnt_r <= 4'd0;
                            par_bad_r <= 1'b0;
                            shift_r   <= 8'h00;
                            state_r   <= ST_DATA;
                        end
                    end else begin
                        bc_r <= bc_r - BC_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bc_r == BC_ZERO) begin
                        shift_r   <= {rxd_s, shift_r[7:1]};
                        bc_r      <= BC_FULL;
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'(DATA_BITS - 1)) begin
                            state_r <= (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        bc_r <= bc_r - BC_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (bc_r == BC_ZERO) begin
                        par_bad_r <= parity_bad(data_s, rxd_s);
                        bc_r      <= BC_FULL;
                        state_r   <= ST_STOP;
                    end else begin
                        bc_r <= bc_r - BC_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bc_r == BC_ZERO) begin
                        state_r <= ST_IDLE;
                    end else begin
                        bc_r <= bc_r - BC_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Stop-sample decisions; a same-cycle pop frees a slot before the full check.
    always_comb begin
        stop_cyc_s    = (state_r == ST_STOP) && (bc_r == BC_ZERO);
        pop_s         = bus.rd_en && !empty_r;
        frame_set_s   = stop_cyc_s && !rxd_s;
        parity_set_s  = stop_cyc_s && rxd_s && par_bad_r;
        overrun_set_s = stop_cyc_s && rxd_s && !par_bad_r && full_r && !pop_s;
        push_s        = stop_cyc_s && rxd_s && !par_bad_r && (!full_r || pop_s);
        count_n_s     = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_s;
        end
    end

    // FIFO pointers and registered occupancy status.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_n_s;
            empty_r <= (count_n_s == CNT_W'(0));
            full_r  <= (count_n_s == CNT_W'(FIFO_DEPTH));
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            frame_err_r  <= frame_set_s   | (frame_err_r  & !bus.err_clr);
            parity_err_r <= parity_set_s  | (parity_err_r & !bus.err_clr);
            overrun_r    <= overrun_set_s | (overrun_r    & !bus.err_clr);
        end
    end

    // Fall-through head view; reads as zero while the FIFO is empty.
    always_comb begin
        if (empty_r) begin
            bus.rd_data = 8'h00;
        end else begin
            bus.rd_data = mem_r[rd_ptr_r];
        end
    end

    assign bus.empty      = empty_r;
    assign bus.full       = full_r;
    assign bus.count      = count_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.parity_err = parity_err_r;
    assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: three instances (8N1, even parity, 4-deep FIFO)
// all at 16 clocks per bit, driven by one linear stimulus sequence.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rxd_v, rd_v, clr_v;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.CNT_W(5)) if_a ();
    uart_rx_fifo_if #(.CNT_W(5)) if_p ();
    uart_rx_fifo_if #(.CNT_W(3)) if_f ();

    assign if_a.uart_rxd = rxd_v[0];
    assign if_a.rd_en    = rd_v[0];
    assign if_a.err_clr  = clr_v[0];
    assign if_p.uart_rxd = rxd_v[1];
    assign if_p.rd_en    = rd_v[1];
    assign if_p.err_clr  = clr_v[1];
    assign if_f.uart_rxd = rxd_v[2];
    assign if_f.rd_en    = rd_v[2];
    assign if_f.err_clr  = clr_v[2];

    uart_rx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_MODE(0), .FIFO_DEPTH(16), .CNT_W(5))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    uart_rx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_MODE(2), .FIFO_DEPTH(16), .CNT_W(5))
        dut_p (.clk(clk), .reset(reset), .bus(if_p));
    uart_rx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_MODE(0), .FIFO_DEPTH(4), .CNT_W(3))
        dut_f (.clk(clk), .reset(reset), .bus(if_f));

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start bit, 8 data bits LSB first, optional parity, stop bit held stop_cyc clocks.
    task automatic send_frame(input int w, input logic [7:0] d, input logic has_par,
                              input logic par, input logic stop, input int stop_cyc);
        rxd_v[w] = 1'b0;
        wait_cyc(16);
        for (int i = 0; i < 8; i++) begin
            rxd_v[w] = d[i];
            wait_cyc(16);
        end
        if (has_par) begin
            rxd_v[w] = par;
            wait_cyc(16);
        end
        rxd_v[w] = stop;
        wait_cyc(stop_cyc);
    endtask

    task automatic pop(input int w);
        rd_v[w] = 1'b1;
        wait_cyc(1);
        rd_v[w] = 1'b0;
    endtask

    task automatic clr(input int w);
        clr_v[w] = 1'b1;
        wait_cyc(1);
        clr_v[w] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rxd_v = 3'b111;
        rd_v  = 3'b000;
        clr_v = 3'b000;
        wait_cyc(3);
        chk("rst_empty", if_a.empty, 1);
        chk("rst_full", if_a.full, 0);
        chk("rst_count", if_a.count, 0);
        chk("rst_rd_data", if_a.rd_data, 0);
        chk("rst_flags", {if_a.frame_err, if_a.parity_err, if_a.overrun}, 0);
        chk("rst_f_count", if_f.count, 0);
        reset = 1'b0;
        wait_cyc(2);

        // 8N1 back-to-back, with exact push timing on the first frame
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 10);
        chk("t1_empty_before_push", if_a.empty, 1);
        wait_cyc(1);
        chk("t1_empty_after_push", if_a.empty, 0);
        chk("t1_count_1", if_a.count, 1);
        wait_cyc(5);
        send_frame(0, 8'hA3, 1'b0, 1'b0, 1'b1, 16);
        chk("t1_count_2", if_a.count, 2);
        chk("t1_head_55", if_a.rd_data, 8'h55);
        pop(0);
        chk("t1_count_1b", if_a.count, 1);
        chk("t1_head_a3", if_a.rd_data, 8'hA3);
        pop(0);
        chk("t1_count_0", if_a.count, 0);
        chk("t1_empty", if_a.empty, 1);
        chk("t1_flags", {if_a.frame_err, if_a.parity_err, if_a.overrun}, 0);

        // glitch shorter than half a bit, then a clean frame
        rxd_v[0] = 1'b0;
        wait_cyc(4);
        rxd_v[0] = 1'b1;
        wait_cyc(40);
        chk("t2_empty", if_a.empty, 1);
        chk("t2_flags", {if_a.frame_err, if_a.parity_err, if_a.overrun}, 0);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 16);
        chk("t2_head_5a", if_a.rd_data, 8'h5A);
        pop(0);

        // framing error, then a good frame with the flag still sticky
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 16);
        rxd_v[0] = 1'b1;
        wait_cyc(32);
        chk("t4_frame_err", if_a.frame_err, 1);
        chk("t4_empty", if_a.empty, 1);
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 16);
        chk("t4_count", if_a.count, 1);
        chk("t4_head_11", if_a.rd_data, 8'h11);
        chk("t4_frame_sticky", if_a.frame_err, 1);
        chk("t4_other_flags", {if_a.parity_err, if_a.overrun}, 0);

        // even parity: 0x07 has three ones, so parity bit 0 is wrong
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 16);
        chk("t3_parity_err", if_p.parity_err, 1);
        chk("t3_empty", if_p.empty, 1);
        clr(1);
        chk("t3_cleared", if_p.parity_err, 0);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 16);
        chk("t3_no_err", if_p.parity_err, 0);
        chk("t3_count", if_p.count, 1);
        chk("t3_head_07", if_p.rd_data, 8'h07);
        pop(1);
        // err_clr coinciding with a new parity error: set wins
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 10);
        clr_v[1] = 1'b1;
        wait_cyc(1);
        clr_v[1] = 1'b0;
        chk("t3_set_wins", if_p.parity_err, 1);
        wait_cyc(5);

        // 4-deep FIFO overrun
        for (int i = 1; i <= 4; i++) send_frame(2, 8'(i), 1'b0, 1'b0, 1'b1, 16);
        chk("t5_full", if_f.full, 1);
        chk("t5_count_4", if_f.count, 4);
        chk("t5_no_overrun_yet", if_f.overrun, 0);
        send_frame(2, 8'h05, 1'b0, 1'b0, 1'b1, 16);
        chk("t5_overrun", if_f.overrun, 1);
        chk("t5_count_still_4", if_f.count, 4);
        for (int i = 1; i <= 4; i++) begin
            chk("t5_read", if_f.rd_data, i);
            pop(2);
        end
        chk("t5_drained", if_f.empty, 1);
        clr(2);
        chk("t5_overrun_clr", if_f.overrun, 0);
        // refill, then pop in the 5th frame's stop-sample cycle
        for (int i = 1; i <= 4; i++) send_frame(2, 8'(i), 1'b0, 1'b0, 1'b1, 16);
        send_frame(2, 8'h05, 1'b0, 1'b0, 1'b1, 10);
        rd_v[2] = 1'b1;
        wait_cyc(1);
        rd_v[2] = 1'b0;
        chk("t5b_no_overrun", if_f.overrun, 0);
        chk("t5b_count_4", if_f.count, 4);
        chk("t5b_full", if_f.full, 1);
        wait_cyc(5);
        for (int i = 2; i <= 5; i++) begin
            chk("t5b_read", if_f.rd_data, i);
            pop(2);
        end
        chk("t5b_drained", if_f.count, 0);

        // reset mid-DATA of 0x9C (0x11 and frame_err still pending on dut_a)
        rxd_v[0] = 1'b0;
        wait_cyc(16);
        rxd_v[0] = 1'b0;
        wait_cyc(16);
        rxd_v[0] = 1'b0;
        wait_cyc(16);
        rxd_v[0] = 1'b1;
        wait_cyc(8);
        reset    = 1'b1;
        rxd_v[0] = 1'b1;
        wait_cyc(2);
        chk("t6_empty", if_a.empty, 1);
        chk("t6_count", if_a.count, 0);
        chk("t6_full", if_a.full, 0);
        chk("t6_rd_data", if_a.rd_data, 0);
        chk("t6_flags", {if_a.frame_err, if_a.parity_err, if_a.overrun}, 0);
        reset = 1'b0;
        wait_cyc(32);
        chk("t6_no_partial", if_a.empty, 1);
        send_frame(0, 8'h42, 1'b0, 1'b0, 1'b1, 16);
        chk("t6_count_1", if_a.count, 1);
        chk("t6_head_42", if_a.rd_data, 8'h42);
        pop(0);
        chk("t6_empty_end", if_a.empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
